mips_instr_encoder: RTL and testbench

//  Builds 32-bit MIPS instruction words (lw, sw, beq, R-type) from field-level requests;
//  the inverse of the opcode decoder that produces lw/sw/beq/regWrite.

---
 rtl/mips_instr_encoder_if.sv | 31 +++
 rtl/mips_instr_encoder.sv | 78 +++++++
 tb/tb_mips_instr_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_instr_encoder_if.sv
// Request/instruction stream bundle between the encoder and its producer/consumer.
interface mips_instr_encoder_if #(
  parameter int unsigned CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [4:0]       req_rs;
  logic [4:0]       req_rt;
  logic [4:0]       req_rd;
  logic [4:0]       req_shamt;
  logic [5:0]       req_funct;
  logic [15:0]      req_imm;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_funct, req_imm,
    input  instr_ready,
    output req_ready, instr_valid, instr, illegal, instr_count
  );

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_funct, req_imm,
    output instr_ready,
    input  req_ready, instr_valid, instr, illegal, instr_count
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Encodes lw/sw/beq/R-type field requests into 32-bit MIPS words and streams
// them out through a small FIFO with a popped-word counter.
module mips_instr_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  mips_instr_encoder_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instr_count;

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_word;

  assign w_full   = (r_occ == OCC_W'(DEPTH));
  assign w_empty  = (r_occ == '0);
  assign w_accept = bus.req_valid && bus.req_ready;
  assign w_push   = w_accept && !bus.req_op[2];
  assign w_pop    = !w_empty && bus.instr_ready && !flush;

  assign bus.req_ready   = !w_full && !flush;
  assign bus.instr_valid = !w_empty;
  assign bus.instr       = w_empty ? 32'h0 : r_mem[r_rd_ptr];
  assign bus.illegal     = r_illegal;
  assign bus.instr_count = r_instr_count;

  // Field packing; op[2] requests never reach the FIFO so only op[1:0] matters here.
  always_comb begin
    w_word = '0;
    case (bus.req_op[1:0])
      2'b00:   w_word = {6'b100011, bus.req_rs, bus.req_rt, bus.req_imm};
      2'b01:   w_word = {6'b101011, bus.req_rs, bus.req_rt, bus.req_imm};
      2'b10:   w_word = {6'b000100, bus.req_rs, bus.req_rt, bus.req_imm};
      default: w_word = {6'b000000, bus.req_rs, bus.req_rt, bus.req_rd,
                         bus.req_shamt, bus.req_funct};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_occ         <= '0;
      r_illegal     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_illegal <= w_accept && bus.req_op[2];
      if (w_pop) r_instr_count <= r_instr_count + CNT_W'(1);
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_occ    <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= w_word;
          r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomized self-checking bench for mips_instr_encoder against a queue-based reference.
module tb_mips_instr_encoder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] q[$];
  int          exp_cnt = 0;
  logic        exp_ill = 1'b0;

  mips_instr_encoder_if #(.CNT_W(CNT_W)) bus ();

  mips_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_encode(input int op, input int rs, input int rt,
                                             input int rd, input int sh, input int fn,
                                             input int imm);
    longint v;
    longint opc;
    opc = (op == 0) ? 35 : (op == 1) ? 43 : (op == 2) ? 4 : 0;
    if (op == 3) v = rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn;
    else         v = opc * 67108864 + rs * 2097152 + rt * 65536 + imm;
    return 32'(v);
  endfunction

  task automatic set_req(input int op, input int rs, input int rt, input int rd,
                         input int sh, input int fn, input int imm);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'(op);
    bus.req_rs    = 5'(rs);
    bus.req_rt    = 5'(rt);
    bus.req_rd    = 5'(rd);
    bus.req_shamt = 5'(sh);
    bus.req_funct = 6'(fn);
    bus.req_imm   = 16'(imm);
  endtask

  task automatic set_rand(input int op);
    set_req(op, $urandom_range(31), $urandom_range(31), $urandom_range(31),
            $urandom_range(31), $urandom_range(63), $urandom_range(65535));
  endtask

  // Advance one clock, moving the reference queue by the transfer rules.
  task automatic tick();
    bit          acc;
    bit          pop;
    bit          ill;
    logic [31:0] word;
    acc  = bus.req_valid && (q.size() < DEPTH) && !flush;
    pop  = (q.size() > 0) && bus.instr_ready && !flush;
    ill  = bus.req_op[2];
    word = ref_encode(int'(bus.req_op), int'(bus.req_rs), int'(bus.req_rt), int'(bus.req_rd),
                      int'(bus.req_shamt), int'(bus.req_funct), int'(bus.req_imm));
    @(posedge clk);
    if (pop) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc && !ill) q.push_back(word);
    end
    exp_ill = acc && ill;
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = 1'b0;
    bus.instr_ready = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0);
    bus.req_valid = 1'b0;
    flush = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    exp_cnt = 0;
    exp_ill = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0 || bus.illegal !== 1'b0 ||
        bus.instr_count !== 4'h0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b instr=%h ill=%b cnt=%0d rdy=%b required 0/0/0/0/1",
               bus.instr_valid, bus.instr, bus.illegal, bus.instr_count, bus.req_ready);
    end
  endtask

  task automatic test_lw();
    bus.instr_ready = 1'b1;
    set_req(0, 2, 5, 0, 0, 0, 16'h0010);
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h8C450010) begin
      errors++;
      $display("FAIL lw_word: valid=%b instr=%h required 1/8c450010", bus.instr_valid, bus.instr);
    end
    tick();
    checks++;
    if (bus.instr_count !== 4'd1 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL lw_pop: cnt=%0d valid=%b required 1/0", bus.instr_count, bus.instr_valid);
    end
  endtask

  task automatic test_sequence();
    logic [31:0] exp_words [3];
    exp_words[0] = 32'hAC64FFFC;
    exp_words[1] = 32'h10220003;
    exp_words[2] = 32'h00221820;
    bus.instr_ready = 1'b0;
    set_req(1, 3, 4, 0, 0, 0, 16'hFFFC);   tick();
    set_req(2, 1, 2, 0, 0, 0, 16'h0003);   tick();
    set_req(3, 1, 2, 3, 0, 6'h20, 16'h0);  tick();
    bus.req_valid = 1'b0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== exp_words[i]) begin
        errors++;
        $display("FAIL seq_word%0d: valid=%b instr=%h required 1/%h",
                 i, bus.instr_valid, bus.instr, exp_words[i]);
      end
      tick();
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.instr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_rand($urandom_range(3));
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready%0d: req_ready=%b required 1", i, bus.req_ready);
      end
      tick();
    end
    set_rand($urandom_range(3));
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: req_ready=%b required 0", bus.req_ready);
    end
    tick();
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || q.size() != DEPTH - 1) begin
      errors++;
      $display("FAIL full_pop_ready: req_ready=%b required 1", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== q[0]) begin
        errors++;
        $display("FAIL full_order%0d: valid=%b instr=%h required 1/%h",
                 i, bus.instr_valid, bus.instr, q[0]);
      end
      tick();
    end
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr_count !== 4'(exp_cnt)) begin
      errors++;
      $display("FAIL full_drain: valid=%b cnt=%0d required 0/%0d",
               bus.instr_valid, bus.instr_count, exp_cnt);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    bus.instr_ready = 1'b0;
    set_rand(0);
    tick();
    set_rand(5);
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if (bus.illegal !== 1'b1 || bus.instr_valid !== 1'b1 || bus.instr !== q[0]) begin
      errors++;
      $display("FAIL illegal_pulse: ill=%b valid=%b instr=%h required 1/1/%h",
               bus.illegal, bus.instr_valid, bus.instr, q[0]);
    end
    tick();
    checks++;
    if (bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: ill=%b required 0", bus.illegal);
    end
    bus.instr_ready = 1'b1;
    tick();
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_occ: valid=%b required 0", bus.instr_valid);
    end
  endtask

  task automatic test_flush();
    int cnt_before;
    bus.instr_ready = 1'b0;
    set_rand(1); tick();
    set_rand(3); tick();
    bus.req_valid = 1'b0;
    cnt_before = exp_cnt;
    flush = 1'b1;
    bus.instr_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: req_ready=%b required 0", bus.req_ready);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0 || bus.instr_count !== 4'(cnt_before)) begin
      errors++;
      $display("FAIL flush_state: valid=%b instr=%h cnt=%0d required 0/0/%0d",
               bus.instr_valid, bus.instr, bus.instr_count, cnt_before);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) < 7) set_rand(($urandom_range(7) == 0) ? 4 + $urandom_range(3)
                                                                  : $urandom_range(3));
      else bus.req_valid = 1'b0;
      bus.instr_ready = ($urandom_range(9) < 6);
      flush = ($urandom_range(19) == 0);
      #1;
      checks++;
      if (bus.req_ready !== ((q.size() < DEPTH) && !flush)) begin
        errors++;
        $display("FAIL rand_ready@%0d: req_ready=%b qsize=%0d flush=%b",
                 i, bus.req_ready, q.size(), flush);
      end
      tick();
      checks++;
      if (bus.instr_valid !== (q.size() > 0) || bus.instr !== ((q.size() > 0) ? q[0] : 32'h0) ||
          bus.illegal !== exp_ill || bus.instr_count !== 4'(exp_cnt)) begin
        errors++;
        $display("FAIL rand_out@%0d: valid=%b instr=%h ill=%b cnt=%0d required %b/%h/%b/%0d",
                 i, bus.instr_valid, bus.instr, bus.illegal, bus.instr_count,
                 q.size() > 0, (q.size() > 0) ? q[0] : 32'h0, exp_ill, exp_cnt);
      end
    end
    flush = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_rand($urandom_range(3));
      tick();
      if (i == 15) begin
        checks++;
        if (bus.instr_count !== 4'd15) begin
          errors++;
          $display("FAIL wrap_15: cnt=%0d required 15", bus.instr_count);
        end
      end
    end
    checks++;
    if (bus.instr_count !== 4'd0 || exp_cnt != 0) begin
      errors++;
      $display("FAIL wrap_0: cnt=%0d required 0", bus.instr_count);
    end
    bus.instr_ready = 1'b0;
    set_rand(3);
    tick();
    set_rand(4);
    tick();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0 || bus.illegal !== 1'b0 ||
        bus.instr_count !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%b instr=%h ill=%b cnt=%0d required all 0",
               bus.instr_valid, bus.instr, bus.illegal, bus.instr_count);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sequence();
    test_full();
    test_illegal();
    test_flush();
    test_random();
    test_wrap_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
